// File: rtl/video_timing_gen.sv
// ---------------------------------------------------------------------------
// video_timing_gen
//
// Raster timing generator.  A divider on CLK_VIDEO produces a one-cycle
// pixel enable every CE_DIV cycles.  The pixel and line counters and the
// sync/blank flags advance on the edge that raises ce_pix, so every pixel's
// values are stable for the whole time ce_pix is high.
//
// Optional feature: define VIDEO_TIMING_FRAME_CNT_EN to build the 16-bit
// frame counter.  Without it, frame_cnt is tied to zero.
//
// Ports
//   CLK_VIDEO    in   1   video clock, the only clock
//   RESET_N      in   1   asynchronous active-low reset
//   run          in   1   1 = generate timing, 0 = hold idle
//   ce_pix       out  1   pixel clock enable, one CLK_VIDEO cycle wide
//   HSync        out  1   horizontal sync, positive-true
//   VSync        out  1   vertical sync, positive-true
//   HBlank       out  1   horizontal blank, positive-true
//   VBlank       out  1   vertical blank, positive-true
//   hcnt         out  12  current pixel within the line
//   vcnt         out  12  current line within the frame
//   frame_start  out  1   high for the pixel at hcnt=0, vcnt=0
//   frame_cnt    out  16  frame counter (zero unless the macro is defined)
// ---------------------------------------------------------------------------
module video_timing_gen #(
  parameter int H_ACTIVE = 720,
  parameter int H_FP     = 12,
  parameter int H_SYNC   = 64,
  parameter int H_BP     = 68,
  parameter int V_ACTIVE = 576,
  parameter int V_FP     = 5,
  parameter int V_SYNC   = 5,
  parameter int V_BP     = 39,
  parameter int CE_DIV   = 2
) (
  input  logic        CLK_VIDEO,
  input  logic        RESET_N,
  input  logic        run,
  output logic        ce_pix,
  output logic        HSync,
  output logic        VSync,
  output logic        HBlank,
  output logic        VBlank,
  output logic [11:0] hcnt,
  output logic [11:0] vcnt,
  output logic        frame_start,
  output logic [15:0] frame_cnt
);

  // All raster boundaries are fixed at elaboration; the datapath only
  // increments counters and compares against these constants.
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [11:0] H_LAST      = 12'(H_TOTAL - 1);
  localparam logic [11:0] H_BLANK_BEG = 12'(H_ACTIVE);
  localparam logic [11:0] H_SYNC_BEG  = 12'(H_ACTIVE + H_FP);
  localparam logic [11:0] H_SYNC_END  = 12'(H_ACTIVE + H_FP + H_SYNC);

  localparam logic [11:0] V_LAST      = 12'(V_TOTAL - 1);
  localparam logic [11:0] V_BLANK_BEG = 12'(V_ACTIVE);
  localparam logic [11:0] V_SYNC_BEG  = 12'(V_ACTIVE + V_FP);
  localparam logic [11:0] V_SYNC_END  = 12'(V_ACTIVE + V_FP + V_SYNC);

  localparam int              DIV_W    = (CE_DIV > 1) ? $clog2(CE_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CE_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);

  // ST_IDLE: no pixel presented yet since run rose, so the first pixel
  // enable presents the raster origin instead of advancing from it.
  typedef enum logic {
    ST_IDLE,
    ST_ACTIVE
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic [DIV_W-1:0] div_q;
  logic             ce_tick;
  logic [11:0]      h_next;
  logic [11:0]      v_next;
  logic             origin_next;

  // State register.
  always_ff @(posedge CLK_VIDEO or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic and the position the next pixel enable will present.
  always_comb begin
    state_d     = state_q;
    ce_tick     = 1'b0;
    h_next      = '0;
    v_next      = '0;
    origin_next = 1'b0;

    if (run && (div_q == DIV_LAST)) begin
      ce_tick = 1'b1;
    end

    if (!run) begin
      state_d = ST_IDLE;
    end else if (ce_tick) begin
      state_d = ST_ACTIVE;
    end

    if (state_q == ST_ACTIVE) begin
      if (hcnt == H_LAST) begin
        h_next = '0;
        v_next = (vcnt == V_LAST) ? 12'd0 : vcnt + 12'd1;
      end else begin
        h_next = hcnt + 12'd1;
        v_next = vcnt;
      end
    end

    origin_next = (h_next == 12'd0) && (v_next == 12'd0);
  end

  // Divider, pixel enable and raster outputs.  Dropping run returns
  // everything to the idle raster on the very next edge, even mid-line.
  always_ff @(posedge CLK_VIDEO or negedge RESET_N) begin
    if (!RESET_N) begin
      div_q       <= '0;
      ce_pix      <= 1'b0;
      hcnt        <= '0;
      vcnt        <= '0;
      HSync       <= 1'b0;
      VSync       <= 1'b0;
      HBlank      <= 1'b1;
      VBlank      <= 1'b1;
      frame_start <= 1'b0;
    end else if (!run) begin
      div_q       <= '0;
      ce_pix      <= 1'b0;
      hcnt        <= '0;
      vcnt        <= '0;
      HSync       <= 1'b0;
      VSync       <= 1'b0;
      HBlank      <= 1'b1;
      VBlank      <= 1'b1;
      frame_start <= 1'b0;
    end else begin
      ce_pix <= ce_tick;
      if (ce_tick) begin
        div_q       <= '0;
        hcnt        <= h_next;
        vcnt        <= v_next;
        HBlank      <= (h_next >= H_BLANK_BEG);
        VBlank      <= (v_next >= V_BLANK_BEG);
        HSync       <= (h_next >= H_SYNC_BEG) && (h_next < H_SYNC_END);
        VSync       <= (v_next >= V_SYNC_BEG) && (v_next < V_SYNC_END);
        frame_start <= origin_next;
      end else begin
        div_q <= div_q + DIV_ONE;
      end
    end
  end

`ifdef VIDEO_TIMING_FRAME_CNT_EN
  logic [15:0] frame_cnt_q;

  // Counts frame_start pulses; it steps on the same edge that raises
  // frame_start and holds its value while run is low.
  always_ff @(posedge CLK_VIDEO or negedge RESET_N) begin
    if (!RESET_N) begin
      frame_cnt_q <= '0;
    end else if (ce_tick && origin_next) begin
      frame_cnt_q <= frame_cnt_q + 16'd1;
    end
  end

  assign frame_cnt = frame_cnt_q;
`else
  assign frame_cnt = '0;
`endif

endmodule

// File: tb/tb_video_timing_gen.sv
// ---------------------------------------------------------------------------
// tb_video_timing_gen
//
// Two instances with the small raster H 8/2/3/2, V 4/1/1/1: dut_a with
// CE_DIV=1 and dut_b with CE_DIV=3.  A raster model derives every output
// from the number of clock edges run has been high, and is compared against
// both instances on every falling edge.  Hand-computed literal checks pin
// the model at chosen points.  Build with +define+VIDEO_TIMING_FRAME_CNT_EN
// to exercise the frame counter.
// ---------------------------------------------------------------------------
module tb_video_timing_gen;

  localparam int H_ACTIVE = 8;
  localparam int H_FP     = 2;
  localparam int H_SYNC   = 3;
  localparam int H_BP     = 2;
  localparam int V_ACTIVE = 4;
  localparam int V_FP     = 1;
  localparam int V_SYNC   = 1;
  localparam int V_BP     = 1;
  localparam int H_TOTAL  = 15;
  localparam int V_TOTAL  = 7;
  localparam int F_TOTAL  = 105;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        run;
  logic        preset_req;

  logic        a_ce, a_hs, a_vs, a_hb, a_vb, a_fs;
  logic [11:0] a_h, a_v;
  logic [15:0] a_fc;
  logic        b_ce, b_hs, b_vs, b_hb, b_vb, b_fs;
  logic [11:0] b_h, b_v;
  logic [15:0] b_fc;

  int          tests = 0;
  int          fails = 0;

  int          rc;
  logic [15:0] base_a;
  logic [15:0] base_b;

  always #5 clk = ~clk;

  video_timing_gen #(
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
    .CE_DIV(1)
  ) dut_a (
    .CLK_VIDEO(clk), .RESET_N(rst_n), .run(run),
    .ce_pix(a_ce), .HSync(a_hs), .VSync(a_vs), .HBlank(a_hb), .VBlank(a_vb),
    .hcnt(a_h), .vcnt(a_v), .frame_start(a_fs), .frame_cnt(a_fc)
  );

  video_timing_gen #(
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
    .CE_DIV(3)
  ) dut_b (
    .CLK_VIDEO(clk), .RESET_N(rst_n), .run(run),
    .ce_pix(b_ce), .HSync(b_hs), .VSync(b_vs), .HBlank(b_hb), .VBlank(b_vb),
    .hcnt(b_h), .vcnt(b_v), .frame_start(b_fs), .frame_cnt(b_fc)
  );

  // Number of frame starts seen during a run period of r edges.
  function automatic int frames_in(input int div, input int r);
    if (r < div) return 0;
    return (r / div - 1) / F_TOTAL + 1;
  endfunction

  // Model state: rc counts consecutive edges with run high; frames from
  // earlier run periods are folded into the per-instance base counts.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rc     <= 0;
      base_a <= '0;
      base_b <= '0;
    end else begin
      if (run) begin
        rc <= rc + 1;
      end else begin
        rc <= 0;
        if (rc != 0) begin
          base_a <= base_a + 16'(frames_in(1, rc));
          base_b <= base_b + 16'(frames_in(3, rc));
        end
      end
      if (preset_req) base_a <= 16'hFFFF;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic compare_dut(input string tag, input int div, input logic [15:0] base,
                             input logic ce, input logic hs, input logic vs,
                             input logic hb, input logic vb, input logic fs,
                             input logic [11:0] h, input logic [11:0] v,
                             input logic [15:0] fc);
    int          p;
    int          eh;
    int          ev;
    logic        pres;
    logic [15:0] efc;
    pres = (rc >= div);
    p    = pres ? (rc / div - 1) : 0;
    eh   = p % H_TOTAL;
    ev   = (p / H_TOTAL) % V_TOTAL;
`ifdef VIDEO_TIMING_FRAME_CNT_EN
    efc  = base + 16'(frames_in(div, rc));
`else
    efc  = 16'd0;
`endif
    chk($sformatf("%s.ce_pix", tag), ce, (rc > 0) && (rc % div == 0));
    chk($sformatf("%s.hcnt", tag), h, eh);
    chk($sformatf("%s.vcnt", tag), v, ev);
    chk($sformatf("%s.HBlank", tag), hb, !pres || (eh >= H_ACTIVE));
    chk($sformatf("%s.VBlank", tag), vb, !pres || (ev >= V_ACTIVE));
    chk($sformatf("%s.HSync", tag), hs,
        pres && (eh >= H_ACTIVE + H_FP) && (eh < H_ACTIVE + H_FP + H_SYNC));
    chk($sformatf("%s.VSync", tag), vs,
        pres && (ev >= V_ACTIVE + V_FP) && (ev < V_ACTIVE + V_FP + V_SYNC));
    chk($sformatf("%s.frame_start", tag), fs, pres && (eh == 0) && (ev == 0));
    chk($sformatf("%s.frame_cnt", tag), fc, efc);
  endtask

  // Compares both instances against the raster model.
  task automatic checkOutput();
    compare_dut("a", 1, base_a, a_ce, a_hs, a_vs, a_hb, a_vb, a_fs, a_h, a_v, a_fc);
    compare_dut("b", 3, base_b, b_ce, b_hs, b_vs, b_hb, b_vb, b_fs, b_h, b_v, b_fc);
  endtask

  task automatic step();
    @(negedge clk);
    checkOutput();
  endtask

  task automatic applyStimulus(input logic run_val, input int cycles);
    run = run_val;
    repeat (cycles) step();
  endtask

  task automatic check_idle_literal(input string tag);
    chk({tag, ".a.ce"}, a_ce, 0);
    chk({tag, ".a.hcnt"}, a_h, 0);
    chk({tag, ".a.vcnt"}, a_v, 0);
    chk({tag, ".a.HBlank"}, a_hb, 1);
    chk({tag, ".a.VBlank"}, a_vb, 1);
    chk({tag, ".a.HSync"}, a_hs, 0);
    chk({tag, ".a.VSync"}, a_vs, 0);
    chk({tag, ".a.frame_start"}, a_fs, 0);
    chk({tag, ".b.ce"}, b_ce, 0);
    chk({tag, ".b.hcnt"}, b_h, 0);
    chk({tag, ".b.HBlank"}, b_hb, 1);
    chk({tag, ".b.frame_start"}, b_fs, 0);
  endtask

  initial begin
    int n;
    rst_n      = 1'b0;
    run        = 1'b0;
    preset_req = 1'b0;
    $display("[TB] start");

    repeat (3) step();
    check_idle_literal("reset");
    chk("reset.a.frame_cnt", a_fc, 0);

    // Release reset with run already high; first pixel on the next edge
    // for CE_DIV=1 and on the third edge for CE_DIV=3.
    rst_n = 1'b1;
    run   = 1'b1;
    for (int k = 1; k <= 315; k++) begin
      step();
      case (k)
        1: begin
          chk("first.a.ce", a_ce, 1);
          chk("first.a.frame_start", a_fs, 1);
          chk("first.a.hcnt", a_h, 0);
          chk("first.b.ce", b_ce, 0);
        end
        2: chk("second.b.ce", b_ce, 0);
        3: begin
          chk("third.b.ce", b_ce, 1);
          chk("third.b.frame_start", b_fs, 1);
        end
        4: begin
          chk("k4.b.ce", b_ce, 0);
          chk("k4.a.hcnt", a_h, 3);
        end
        6: begin
          chk("k6.b.ce", b_ce, 1);
          chk("k6.b.hcnt", b_h, 1);
        end
        8: begin
          chk("h7.a.hcnt", a_h, 7);
          chk("h7.a.HBlank", a_hb, 0);
        end
        9: begin
          chk("h8.a.hcnt", a_h, 8);
          chk("h8.a.HBlank", a_hb, 1);
          chk("h8.a.HSync", a_hs, 0);
        end
        11: begin
          chk("h10.a.hcnt", a_h, 10);
          chk("h10.a.HSync", a_hs, 1);
        end
        13: chk("h12.a.HSync", a_hs, 1);
        14: chk("h13.a.HSync", a_hs, 0);
        15: begin
          chk("h14.a.hcnt", a_h, 14);
          chk("h14.a.HBlank", a_hb, 1);
        end
        16: begin
          chk("wrap.a.hcnt", a_h, 0);
          chk("wrap.a.vcnt", a_v, 1);
          chk("wrap.a.HBlank", a_hb, 0);
        end
        61: begin
          chk("v4.a.VBlank", a_vb, 1);
          chk("v4.a.VSync", a_vs, 0);
        end
        76: begin
          chk("v5.a.vcnt", a_v, 5);
          chk("v5.a.VSync", a_vs, 1);
        end
        90: chk("v5end.a.VSync", a_vs, 1);
        91: begin
          chk("v6.a.vcnt", a_v, 6);
          chk("v6.a.VSync", a_vs, 0);
        end
        106: begin
          chk("frame2.a.hcnt", a_h, 0);
          chk("frame2.a.vcnt", a_v, 0);
          chk("frame2.a.frame_start", a_fs, 1);
        end
        107: chk("frame2.a.frame_start_low", a_fs, 0);
        default: ;
      endcase
    end
`ifdef VIDEO_TIMING_FRAME_CNT_EN
    chk("three_frames.a.frame_cnt", a_fc, 3);
    chk("three_frames.b.frame_cnt", b_fc, 1);
`else
    chk("three_frames.a.frame_cnt", a_fc, 0);
    chk("three_frames.b.frame_cnt", b_fc, 0);
`endif

    // Drop run mid-frame at hcnt=5, vcnt=2.
    n = 0;
    while (!(a_h == 12'd5 && a_v == 12'd2) && n < 200) begin
      step();
      n++;
    end
    chk("drop_point.reached", (a_h == 12'd5) && (a_v == 12'd2), 1);
    applyStimulus(1'b0, 1);
    check_idle_literal("drop");
    applyStimulus(1'b0, 2);

`ifdef VIDEO_TIMING_FRAME_CNT_EN
    force dut_a.frame_cnt_q = 16'hFFFF;
    preset_req = 1'b1;
    step();
    release dut_a.frame_cnt_q;
    preset_req = 1'b0;
    chk("preset.a.frame_cnt", a_fc, 16'hFFFF);
`endif

    // Restore run: the first pixel is again the raster origin.
    run = 1'b1;
    for (int k = 1; k <= 110; k++) begin
      step();
      case (k)
        1: begin
          chk("restart.a.ce", a_ce, 1);
          chk("restart.a.frame_start", a_fs, 1);
          chk("restart.a.frame_cnt_wrap", a_fc, 0);
        end
        3: begin
          chk("restart.b.ce", b_ce, 1);
          chk("restart.b.frame_start", b_fs, 1);
        end
        105: chk("one_frame.a.frame_cnt", a_fc, 0);
        110: begin
          chk("premid.a.hcnt", a_h, 4);
          chk("premid.a.HBlank", a_hb, 0);
          chk("premid.a.VBlank", a_vb, 0);
        end
        default: ;
      endcase
    end

    // Asynchronous reset between clock edges.
    #2 rst_n = 1'b0;
    #1;
    check_idle_literal("async_reset");
    chk("async_reset.a.frame_cnt", a_fc, 0);
    chk("async_reset.b.frame_cnt", b_fc, 0);
    repeat (2) step();
    rst_n = 1'b1;
    step();
    chk("post_reset.a.ce", a_ce, 1);
    chk("post_reset.a.frame_start", a_fs, 1);
    repeat (5) step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
